// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared types for the register-bank write arbiter: sequencer states, requester ID,
// and hold-counter sizing.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef logic req_id_t;

    // Counter must hold HOLD_CYCLES-1; never narrower than one bit.
    function automatic int unsigned hold_cnt_w(input int unsigned hold);
        int unsigned w;
        w = $clog2(hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int unsigned HOLD_CNT_W_DEFAULT = hold_cnt_w(2);

endpackage

// File: rtl/reg_bank_write_arbiter_if.sv
// Bus bundle between the two write masters, the arbiter and the register bank.
interface reg_bank_write_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              REQ0;
    logic [ADDR_W-1:0] ADDR0;
    logic [DATA_W-1:0] DATA0;
    logic              REQ1;
    logic [ADDR_W-1:0] ADDR1;
    logic [DATA_W-1:0] DATA1;
    logic              ACK0;
    logic              ACK1;
    logic              WE;
    logic [ADDR_W-1:0] WADDR;
    logic [DATA_W-1:0] WDATA;
    logic              BUSY;

    modport master (
        output REQ0, ADDR0, DATA0, REQ1, ADDR1, DATA1,
        input  ACK0, ACK1, WE, WADDR, WDATA, BUSY
    );

    modport slave (
        input  REQ0, ADDR0, DATA0, REQ1, ADDR1, DATA1,
        output ACK0, ACK1, WE, WADDR, WDATA, BUSY
    );
endinterface

// File: rtl/reg_bank_write_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; PTR only matters when both request.
module rr_pick2
    import reg_arb_pkg::*;
(
    input  logic    REQ0,
    input  logic    REQ1,
    input  req_id_t PTR,
    output logic    GRANT_VALID,
    output req_id_t GRANT_ID
);
    always_comb begin
        GRANT_VALID = REQ0 | REQ1;
        GRANT_ID    = (REQ0 && REQ1) ? PTR : req_id_t'(REQ1);
    end
endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write sequencer: grant, one setup cycle, HOLD_CYCLES of WE, then ACK.
module reg_bank_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 2,
    parameter int HOLD_CYCLES = 2
) (
    input  logic CLK,
    input  logic RST,
    reg_bank_write_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = hold_cnt_w(HOLD_CYCLES);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("reg_bank_write_arbiter: HOLD_CYCLES must be >= 1");
    end

    state_t            r_state;
    req_id_t           r_ptr;
    req_id_t           r_winner;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_busy;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_grant_valid;
    req_id_t           w_grant_id;

    rr_pick2 u_pick (
        .REQ0        (bus.REQ0),
        .REQ1        (bus.REQ1),
        .PTR         (r_ptr),
        .GRANT_VALID (w_grant_valid),
        .GRANT_ID    (w_grant_id)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_ptr    <= 1'b0;
            r_winner <= 1'b0;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_busy   <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_state  <= SETUP;
                        r_busy   <= 1'b1;
                        r_winner <= w_grant_id;
                        r_waddr  <= w_grant_id ? bus.ADDR1 : bus.ADDR0;
                        r_wdata  <= w_grant_id ? bus.DATA1 : bus.DATA0;
                    end
                end
                SETUP: begin
                    r_state <= STROBE;
                    r_we    <= 1'b1;
                    r_cnt   <= CNT_W'(HOLD_CYCLES - 1);
                end
                STROBE: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_we    <= 1'b0;
                        r_ack0  <= ~r_winner;
                        r_ack1  <= r_winner;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ptr   <= ~r_winner;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.WE    = r_we;
    assign bus.ACK0  = r_ack0;
    assign bus.ACK1  = r_ack1;
    assign bus.BUSY  = r_busy;
    assign bus.WADDR = r_waddr;
    assign bus.WDATA = r_wdata;

endmodule

// File: doc/reg_bank_write_arbiter.md
Name: reg_bank_write_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single write port of a small register bank built from the team's master-slave D flip-flops.
- Captures one winning request, then drives address and data for a setup cycle before raising the write strobe, so the slave stage always sees stable D.
- Holds the strobe for a programmable number of cycles, then acknowledges the winner.
- Sits between the two bus masters and the register bank.

Parameters:
- DATA_W, 8, width of write data.
- ADDR_W, 2, width of register address (bank depth 2**ADDR_W).
- HOLD_CYCLES, 2, cycles WE stays high per write. Must be >= 1; elaboration error otherwise.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ0  input  1  requester 0 write request; held until ACK0.
- ADDR0  input  ADDR_W  requester 0 target register.
- DATA0  input  DATA_W  requester 0 write data.
- REQ1  input  1  requester 1 write request.
- ADDR1  input  ADDR_W  requester 1 target register.
- DATA1  input  DATA_W  requester 1 write data.
- ACK0  output  1  one-cycle completion pulse to requester 0.
- ACK1  output  1  one-cycle completion pulse to requester 1.
- WE  output  1  register bank write strobe.
- WADDR  output  ADDR_W  register bank write address.
- WDATA  output  DATA_W  register bank write data.
- BUSY  output  1  high whenever state != IDLE.

Behaviour:
- Reset is synchronous: the rising edge with RST=1 forces the following.
  - State = IDLE, priority pointer PTR = 0.
  - All outputs 0 (WE, ACK0, ACK1, BUSY, WADDR, WDATA).
  - Hold counter = 0.
- Reset mid-transaction: abort, no ACK issued. WE is low from the reset edge onward; the write in progress is abandoned.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE -> SETUP -> STROBE -> DONE -> IDLE.
- IDLE:
  - If neither REQ is high, stay in IDLE.
  - If exactly one REQ is high, grant that requester regardless of PTR.
  - If both are high, grant the requester equal to PTR.
  - On the grant edge: capture winner's ADDR/DATA into WADDR/WDATA, record the winner ID, go to SETUP.
- SETUP: exactly 1 cycle with WE=0 and WADDR/WDATA stable. Go to STROBE and load the counter with HOLD_CYCLES-1.
- STROBE:
  - WE=1 for exactly HOLD_CYCLES cycles; the counter decrements each cycle.
  - At counter = 0, go to DONE.
- DONE:
  - WE=0 and exactly one cycle of ACK for the winner (ACK0 and ACK1 are never both high).
  - PTR <= ~winner; go to IDLE.
- WADDR/WDATA hold their values through SETUP, STROBE and DONE, and keep the last value in IDLE until the next grant.
- Inputs are sampled only at the grant edge. Later changes to ADDRx/DATAx, or REQx dropping mid-transaction, do not affect the transfer, which completes and ACKs normally.
- Latency, with REQ sampled high at grant edge k:
  - WE is high after edges k+1 .. k+HOLD_CYCLES.
  - ACK is high after edge k+1+HOLD_CYCLES.
  - BUSY is high from edge k until the edge that returns to IDLE.
- Requester protocol: REQ is deasserted in the cycle ACK is seen. If REQ is still high in the following IDLE cycle, it is treated as a new request.
- Back-to-back transactions: there is always exactly one IDLE cycle between DONE and the next grant. Max throughput is one write per HOLD_CYCLES+3 cycles.
- Fairness: with both REQs continuously high, grants strictly alternate, beginning with requester 0 after reset.

Decomposition:
- Package reg_arb_pkg:
  - state enum (IDLE, SETUP, STROBE, DONE);
  - requester ID type (1 bit);
  - localparam for the hold counter width: $clog2(HOLD_CYCLES+1), minimum 1.
- One natural sub-module, rr_pick2: a combinational 2-way round-robin picker.
  - Inputs: REQ0, REQ1, PTR.
  - Outputs: GRANT_VALID, GRANT_ID.
  - Reused by future bank read arbiters.
- FSM, counter and output registers live in the top module.

Test Plan:
- Reset with RST=1 for 2 cycles while REQ0=REQ1=1 -> all outputs 0, BUSY=0, no grant until the cycle after RST falls.
- Single request, HOLD_CYCLES=2: REQ0=1, ADDR0=2'b01, DATA0=8'hA5 at edge k -> WADDR=01, WDATA=A5 after edge k; WE=1 after edges k+1 and k+2; ACK0=1 after edge k+3 for one cycle; BUSY=1 for 4 cycles.
- Simultaneous requests after reset: REQ0=1 (ADDR 0, DATA 8'h11), REQ1=1 (ADDR 3, DATA 8'h22), both held until their ACK -> requester 0 is served first (ACK0). After one IDLE cycle, requester 1 is served (WADDR=3, WDATA=22, ACK1). Then, with both re-requesting, the next grant goes to requester 0.
- Mid-transaction input change: after the grant, change DATA0 to 8'hFF and drop REQ0 during STROBE -> WDATA stays at the captured value and ACK0 still pulses.
- Reset mid-STROBE: assert RST=1 for one cycle while WE=1 -> WE=0 and BUSY=0 after that edge, no ACK ever issued, PTR=0.
- HOLD_CYCLES=1 build: REQ1 alone -> WE high for exactly 1 cycle, ACK1 two cycles after the grant edge.
